sram_master: RTL and testbench

//  Initiator for the single-port synchronous data RAM (cs/oe/we/addr/din/dout, 1-cycle registered read).

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_lane_align.sv | 70 +++++++
 rtl/sram_master.sv | 152 +++++++++++++++
 tb/tb_sram_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-RAM initiator: access-size
//                encodings, the initiator FSM state type and the alignment
//                check used when a request is accepted.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Initiator FSM states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WAIT   = 3'd3,
        S_WR     = 3'd4,
        S_ERR    = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    // Natural-alignment check; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational lane steering between a 32-bit RAM word and a
//                byte/half/word access. Extracts and extends a load from the
//                addressed lane, and merges the low byte/half of store data
//                into the addressed lane of a word read back from RAM.
//  Ports       : i_size       access size (mem_pkg SZ_*)
//                i_unsigned   1 = zero-extend loads, 0 = sign-extend
//                i_addr_lo    byte offset within the word
//                i_rdata      word read from RAM
//                i_wdata      right-justified store data
//                o_load_data  extracted, extended load value
//                o_merged     i_rdata with the store lane replaced
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lane_align
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane;

    always_comb begin
        w_shift     = 5'd0;
        w_mask      = 32'hFFFF_FFFF;
        o_load_data = i_rdata;
        // In big-endian order byte 0 sits in the top lane, so the shift is
        // the bit-inverted offset (3 - k) rather than k.
        case (i_size)
            SZ_BYTE: begin
                w_shift = BIG_ENDIAN ? {~i_addr_lo, 3'b000} : {i_addr_lo, 3'b000};
                w_mask  = 32'h0000_00FF;
            end
            SZ_HALF: begin
                w_shift = BIG_ENDIAN ? {~i_addr_lo[1], 4'b0000} : {i_addr_lo[1], 4'b0000};
                w_mask  = 32'h0000_FFFF;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase

        w_lane = i_rdata >> w_shift;

        case (i_size)
            SZ_BYTE: o_load_data = i_unsigned ? {24'd0, w_lane[7:0]}
                                              : {{24{w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: o_load_data = i_unsigned ? {16'd0, w_lane[15:0]}
                                              : {{16{w_lane[15]}}, w_lane[15:0]};
            default: o_load_data = i_rdata;
        endcase

        o_merged = (i_rdata & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/sram_master.sv
`default_nettype none
// ============================================================================
//  Module      : sram_master
//  Description : Single-outstanding load/store initiator for a single-port
//                synchronous data RAM. Accepts a request over valid/ready,
//                drives cs/oe/we, extends loads, does read-modify-write for
//                sub-word stores and returns a one-cycle response pulse.
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                req_*                     request channel (valid/ready)
//                resp_valid/rdata/err      one-cycle completion
//                mem_cs/oe/we/addr/din     RAM strobes and write data
//                mem_dout                  RAM read data
//  Revision    : 1.0  initial release
// ============================================================================
module sram_master
    import mem_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int unsigned c_CNT_W = $clog2(RD_LAT + 1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [31:0]          r_addr;
    logic [31:0]          r_din;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_accept;
    logic                 w_bad;
    logic                 w_last_wait;
    logic [31:0]          w_load_data;
    logic [31:0]          w_merged;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_bad       = is_misaligned(req_size, req_addr[1:0]) || (req_size == SZ_RSVD);
    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == c_CNT_W'(1));

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_addr_lo   (r_addr[1:0]),
        .i_rdata     (mem_dout),
        .i_wdata     (r_din),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_bad)                    w_next = S_ERR;
                    else if (!req_we)             w_next = S_RD;
                    else if (req_size == SZ_WORD) w_next = S_WR;
                    else                          w_next = S_RMW_RD;
                end
            end
            S_RD, S_RMW_RD: w_next = S_WAIT;
            S_WAIT:         if (w_last_wait) w_next = r_we ? S_WR : S_RESP;
            S_WR:           w_next = S_RESP;
            S_ERR:          w_next = S_RESP;
            S_RESP:         w_next = S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Request fields and datapath. r_din holds the right-justified store data
    // until the RMW read returns, then is replaced by the merged word that
    // the WR state writes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_din      <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_din      <= req_wdata;
                r_rdata    <= 32'd0;
                r_err      <= w_bad;
            end
            if ((r_state == S_RD) || (r_state == S_RMW_RD)) begin
                r_cnt <= c_CNT_W'(RD_LAT);
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
                if (w_last_wait) begin
                    if (r_we) r_din   <= w_merged;
                    else      r_rdata <= w_load_data;
                end
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = r_rdata;

    assign mem_cs   = (r_state == S_RD) || (r_state == S_RMW_RD) || (r_state == S_WR);
    assign mem_oe   = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign mem_we   = (r_state == S_WR);
    assign mem_addr = {r_addr[31:2], 2'b00};
    assign mem_din  = r_din;

endmodule : sram_master
`default_nettype wire

// File: tb/tb_sram_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_master
//  Description : Directed self-checking bench for sram_master. Two instances
//                (RD_LAT=1 and RD_LAT=3), each with a behavioural RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        v3 = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy1, rv1, re1, cs1, oe1, we1;
    logic [31:0] rd1, ad1, di1;
    logic [31:0] do1 = 32'd0;
    logic        rdy3, rv3, re3, cs3, oe3, we3;
    logic [31:0] rd3, ad3, di3;
    logic [31:0] do3 = 32'd0;

    // Backdoor preload port into both RAM models
    logic        bk_we = 1'b0;
    logic [5:0]  bk_idx = 6'd0;
    logic [31:0] bk_data = 32'd0;

    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic [31:0] p3a = 32'd0;
    logic [31:0] p3b = 32'd0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_master #(.BIG_ENDIAN(1'b1), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1),
        .mem_cs(cs1), .mem_oe(oe1), .mem_we(we1),
        .mem_addr(ad1), .mem_din(di1), .mem_dout(do1)
    );

    sram_master #(.BIG_ENDIAN(1'b1), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3),
        .mem_cs(cs3), .mem_oe(oe3), .mem_we(we3),
        .mem_addr(ad3), .mem_din(di3), .mem_dout(do3)
    );

    // RAM with 1-cycle registered read
    always @(posedge clk) begin
        if (bk_we) ram1[bk_idx] <= bk_data;
        if (cs1 && we1) ram1[ad1[7:2]] <= di1;
        if (cs1 && oe1) do1 <= ram1[ad1[7:2]];
    end

    // RAM with 3-cycle read pipeline
    always @(posedge clk) begin
        if (bk_we) ram3[bk_idx] <= bk_data;
        if (cs3 && we3) ram3[ad3[7:2]] <= di3;
        if (cs3 && oe3) p3a <= ram3[ad3[7:2]];
        p3b <= p3a;
        do3 <= p3b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        bk_we = 1'b1; bk_idx = idx; bk_data = data;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    // Issue one request on u_dut. Called at a negedge. lat counts posedges
    // from the accept edge to the edge that samples resp_valid high.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit keep,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output bit cs_seen, output int nwait);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        nwait = 0; cs_seen = 1'b0; lat = 0; rdata = 32'd0; err = 1'b0;
        while (!rdy1 && nwait < 20) begin
            @(negedge clk);
            nwait++;
        end
        @(posedge clk);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 0 && !keep) req_valid = 1'b0;
            if (cs1) cs_seen = 1'b1;
            if (rv1) begin
                lat = k + 1;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
        rdata = rd1;
        err   = re1;
    endtask

    int          lat, nw;
    logic [31:0] rdata;
    logic        err;
    bit          cs_seen;

    initial begin
        rst = 1'b1;
        preload(6'd4,  32'hDEAD_BEEF);
        preload(6'd12, 32'h1122_3344);
        preload(6'd8,  32'h0000_0000);
        @(negedge clk);

        // Reset state
        chk("rst_ready",   {31'd0, rdy1}, 32'd1);
        chk("rst_rvalid",  {31'd0, rv1},  32'd0);
        chk("rst_strobes", {29'd0, cs1, oe1, we1}, 32'd0);
        chk("rst_addr",    ad1, 32'd0);
        chk("rst_din",     di1, 32'd0);
        chk("rst_rdata",   rd1, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-RMW: sb @0x31, rst while in WAIT
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_rd_oe", {30'd0, cs1, oe1}, 32'd3);
        @(negedge clk);
        chk("wait_cs", {31'd0, cs1}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready",   {31'd0, rdy1}, 32'd1);
        chk("midrst_outs",    {28'd0, rv1, cs1, oe1, we1}, 32'd0);
        chk("midrst_addr",    ad1, 32'd0);
        chk("midrst_din",     di1, 32'd0);
        chk("midrst_rdata",   rd1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", {30'd0, rv1, we1}, 32'd0);
        end
        chk("midrst_ram", ram1[12], 32'h1122_3344);

        // Word load
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lw_lat", lat, 32'd3);
        chk("lw_data", rdata, 32'hDEAD_BEEF);
        chk("lw_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("resp_pulse", {31'd0, rv1}, 32'd0);

        // Sub-word loads
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lb_13", rdata, 32'hFFFF_FFEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lbu_11", rdata, 32'h0000_00AD);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lh_12", rdata, 32'hFFFF_BEEF);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lhu_10", rdata, 32'h0000_DEAD);

        // Sub-word stores (upper wdata bits must be ignored)
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA55, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("sb_lat", lat, 32'd4);
        chk("sb_rdata", rdata, 32'd0);
        chk("sb_ram", ram1[4], 32'hDE55_BEEF);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("sh_ram", ram1[4], 32'hDE55_1234);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lw_after_st", rdata, 32'hDE55_1234);

        // Misaligned and reserved-size requests
        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("lw_mis_err", {31'd0, err}, 32'd1);
        chk("lw_mis_lat", lat, 32'd2);
        chk("lw_mis_cs", {31'd0, cs_seen}, 32'd0);
        chk("lw_mis_rdata", rdata, 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h9999, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("sh_mis_err", {31'd0, err}, 32'd1);
        chk("sh_mis_lat", lat, 32'd2);
        chk("sh_mis_cs", {31'd0, cs_seen}, 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("rsvd_err", {31'd0, err}, 32'd1);
        chk("ram_untouched", ram1[4], 32'hDE55_1234);

        // Back-to-back with req_valid held high
        @(negedge clk);
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1, lat, rdata, err, cs_seen, nw);
        chk("sw_lat", lat, 32'd2);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, lat, rdata, err, cs_seen, nw);
        chk("b2b_wait", nw, 32'd1);
        chk("b2b_lat", lat, 32'd3);
        chk("b2b_rdata", rdata, 32'hCAFE_F00D);

        // RD_LAT=3 instance: load takes two extra cycles
        @(negedge clk);
        preload(6'd8, 32'hCAFE_F00D);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; v3 = 1'b1;
        chk("l3_ready", {31'd0, rdy3}, 32'd1);
        @(posedge clk);
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 0) v3 = 1'b0;
            if (rv3) begin
                lat = k + 1;
                break;
            end
        end
        chk("l3_lat", lat, 32'd5);
        chk("l3_rdata", rd3, 32'hCAFE_F00D);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sram_master
`default_nettype wire
